// File: rtl/sprite_blit_engine.sv
// rtl/sprite_blit_engine.sv - sprite copy engine: streams a ROM rectangle into the frame writer
//
// Purpose: on execute, latch a sprite job and issue one ROM address per
// cycle (row-major). One cycle later, emit a clipped, colour-keyed pixel
// write to the SRAM controller's program port.
// Ports:
//   clk, reset_n                    clock, synchronous active-low reset
//   execute                         job start request (level)
//   src_base, width, height         sprite location in ROM and size (0 = empty job)
//   dest_x, dest_y                  signed screen position of texel (0,0)
//   key_en, key_color               transparent-colour keying
//   src_addr / src_data             ROM read port (1-cycle read latency)
//   program_x/y/data/write          pixel write strobe and payload
//   busy, done                      job status
module sprite_blit_engine #(
  parameter int ADDR_W   = 18,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              execute,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [9:0]        width,
  input  logic [9:0]        height,
  input  logic [10:0]       dest_x,
  input  logic [10:0]       dest_y,
  input  logic              key_en,
  input  logic [15:0]       key_color,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [15:0]       src_data,
  output logic [9:0]        program_x,
  output logic [9:0]        program_y,
  output logic [15:0]       program_data,
  output logic              program_write,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_COPY  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [11:0] SW = 12'(SCREEN_W);
  localparam logic [11:0] SH = 12'(SCREEN_H);

  logic [1:0]  state;
  logic [9:0]  width_q, height_q;
  logic [10:0] dest_x_q, dest_y_q;
  logic        key_en_q;
  logic [15:0] key_color_q;
  logic [9:0]  col, row;

  // Write-stage registers: the texel whose ROM data arrives this cycle.
  logic        wvalid;
  logic [9:0]  wcol, wrow;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      src_addr    <= '0;
      width_q     <= '0;
      height_q    <= '0;
      dest_x_q    <= '0;
      dest_y_q    <= '0;
      key_en_q    <= 1'b0;
      key_color_q <= '0;
      col         <= '0;
      row         <= '0;
      wvalid      <= 1'b0;
      wcol        <= '0;
      wrow        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          wvalid <= 1'b0;
          if (execute) begin
            width_q     <= width;
            height_q    <= height;
            dest_x_q    <= dest_x;
            dest_y_q    <= dest_y;
            key_en_q    <= key_en;
            key_color_q <= key_color;
            col         <= '0;
            row         <= '0;
            src_addr    <= src_base;
            state       <= (width == 10'd0 || height == 10'd0) ? S_DONE : S_COPY;
          end
        end
        S_COPY: begin
          wvalid   <= 1'b1;
          wcol     <= col;
          wrow     <= row;
          // Running address counter; wraps naturally at 2^ADDR_W.
          src_addr <= src_addr + ADDR_W'(1);
          if (col == width_q - 10'd1) begin
            col <= '0;
            if (row == height_q - 10'd1) begin
              state <= S_DRAIN;
            end else begin
              row <= row + 10'd1;
            end
          end else begin
            col <= col + 10'd1;
          end
        end
        S_DRAIN: begin
          wvalid <= 1'b0;
          state  <= S_DONE;
        end
        default: begin
          wvalid <= 1'b0;
          // Level-sensitive start: require execute to drop before re-arming.
          if (!execute) state <= S_IDLE;
        end
      endcase
    end
  end

  // Screen coordinates in 12-bit two's complement; bit 11 set means negative.
  logic [11:0] sx, sy;
  logic        active, on_screen, keyed;

  always_comb begin
    sx        = {dest_x_q[10], dest_x_q} + {2'b00, wcol};
    sy        = {dest_y_q[10], dest_y_q} + {2'b00, wrow};
    active    = wvalid && (state == S_COPY || state == S_DRAIN);
    on_screen = !sx[11] && (sx < SW) && !sy[11] && (sy < SH);
    keyed     = key_en_q && (src_data == key_color_q);
  end

  assign program_write = active && on_screen && !keyed;
  assign program_x     = active ? sx[9:0] : 10'd0;
  assign program_y     = active ? sy[9:0] : 10'd0;
  assign program_data  = active ? src_data : 16'd0;
  assign busy          = (state == S_COPY) || (state == S_DRAIN);
  assign done          = (state == S_DONE);

endmodule
